// File: rtl/ibex_pkg.sv
// Shared types for the EX-stage functional-unit sequencer.
package ibex_pkg;

    typedef enum logic [1:0] {
        EX_SEQ_IDLE,
        EX_SEQ_BUSY,
        EX_SEQ_HOLD
    } ex_seq_state_e;

    localparam int unsigned EX_SEQ_MAX_CYCLES = 64;

endpackage

// File: rtl/ibex_ex_imd_regs.sv
// Purpose: two shared intermediate-value registers, written only by the owning unit.
// Latency: writes land on the next clk_i edge; both registers may be written together.
// Backpressure: none; clear_i has priority over any write.
module ibex_ex_imd_regs #(
    parameter int unsigned NumFu    = 3,
    parameter int unsigned ImdWidth = 34,
    localparam int unsigned FuIdxW  = $clog2(NumFu)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         wr_en_i,
    input  logic [FuIdxW-1:0]            owner_i,
    input  logic [2*NumFu-1:0]           we_i,
    input  logic [2*NumFu*ImdWidth-1:0]  d_i,
    output logic [2*ImdWidth-1:0]        imd_val_q_o
);

    logic [ImdWidth-1:0] imd0_q, imd0_d;
    logic [ImdWidth-1:0] imd1_q, imd1_d;

    always_comb begin
        imd0_d = imd0_q;
        imd1_d = imd1_q;
        if (clear_i) begin
            imd0_d = '0;
            imd1_d = '0;
        end else if (wr_en_i) begin
            // Non-owner enables are simply never selected.
            for (int unsigned i = 0; i < NumFu; i++) begin
                if (owner_i == FuIdxW'(i)) begin
                    if (we_i[2*i])   imd0_d = d_i[(2*i)*ImdWidth +: ImdWidth];
                    if (we_i[2*i+1]) imd1_d = d_i[(2*i+1)*ImdWidth +: ImdWidth];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            imd0_q <= '0;
            imd1_q <= '0;
        end else begin
            imd0_q <= imd0_d;
            imd1_q <= imd1_d;
        end
    end

    assign imd_val_q_o = {imd1_q, imd0_q};

endmodule

// File: rtl/ibex_ex_fu_seq.sv
// Purpose: issues one op to one of NumFu units, watches it, returns a single result to ID.
// Latency: combinational units return in the issue cycle; others when their valid arrives.
// Backpressure: result stalls in HOLD until result_ready_i; no issue accepted outside IDLE.
module ibex_ex_fu_seq
    import ibex_pkg::*;
#(
    parameter int unsigned     NumFu      = 3,
    parameter int unsigned     DataWidth  = 32,
    parameter int unsigned     ImdWidth   = 34,
    parameter logic [NumFu-1:0] CombFuMask = NumFu'(1),
    parameter int unsigned     MaxCycles  = EX_SEQ_MAX_CYCLES,
    localparam int unsigned    FuIdxW     = $clog2(NumFu),
    localparam int unsigned    CntW       = $clog2(MaxCycles)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         issue_valid_i,
    output logic                         issue_ready_o,
    input  logic [FuIdxW-1:0]            issue_fu_i,
    input  logic                         kill_i,
    output logic [NumFu-1:0]             fu_start_o,
    output logic [NumFu-1:0]             fu_sel_o,
    output logic [NumFu-1:0]             fu_kill_o,
    input  logic [NumFu-1:0]             fu_valid_i,
    input  logic [NumFu*DataWidth-1:0]   fu_result_i,
    input  logic [2*NumFu-1:0]           fu_imd_we_i,
    input  logic [2*NumFu*ImdWidth-1:0]  fu_imd_d_i,
    output logic [2*ImdWidth-1:0]        imd_val_q_o,
    output logic [DataWidth-1:0]         result_o,
    output logic                         result_valid_o,
    input  logic                         result_ready_i,
    output logic                         timeout_o,
    output logic                         err_o
);

    ex_seq_state_e       state_q, state_d;
    logic [FuIdxW-1:0]   owner_q, owner_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DataWidth-1:0] res_q, res_d;
    logic                init_q;

    logic                active;
    logic [NumFu-1:0]    issue_oh, owner_oh;
    logic [DataWidth-1:0] issue_res, owner_res;
    logic                owner_vld, foreign_vld, expire;

    // The cycle after reset is kept quiet as well as the reset cycle itself.
    assign active = rst_ni & init_q;

    always_comb begin
        issue_res = '0;
        owner_res = '0;
        for (int unsigned i = 0; i < NumFu; i++) begin
            issue_oh[i] = (issue_fu_i == FuIdxW'(i));
            owner_oh[i] = (owner_q == FuIdxW'(i));
            if (issue_oh[i]) issue_res |= fu_result_i[i*DataWidth +: DataWidth];
            if (owner_oh[i]) owner_res |= fu_result_i[i*DataWidth +: DataWidth];
        end
    end

    assign owner_vld   = |(fu_valid_i & owner_oh);
    assign foreign_vld = |(fu_valid_i & ~owner_oh);
    // Expire when the incremented count would reach MaxCycles-1.
    assign expire      = (cnt_q == CntW'(MaxCycles - 2));

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        cnt_d          = cnt_q;
        res_d          = res_q;
        issue_ready_o  = 1'b0;
        fu_start_o     = '0;
        fu_sel_o       = '0;
        fu_kill_o      = '0;
        result_o       = res_q;
        result_valid_o = 1'b0;
        timeout_o      = 1'b0;
        err_o          = 1'b0;

        if (active) begin
            unique case (state_q)
                EX_SEQ_IDLE: begin
                    issue_ready_o = ~kill_i;
                    if (issue_valid_i && !kill_i) begin
                        if (!(|issue_oh)) begin
                            err_o = 1'b1;
                        end else if (|(issue_oh & CombFuMask)) begin
                            result_o       = issue_res;
                            result_valid_o = 1'b1;
                            if (!result_ready_i) begin
                                res_d   = issue_res;
                                state_d = EX_SEQ_HOLD;
                            end
                        end else begin
                            fu_start_o = issue_oh;
                            owner_d    = issue_fu_i;
                            cnt_d      = '0;
                            state_d    = EX_SEQ_BUSY;
                        end
                    end
                end
                EX_SEQ_BUSY: begin
                    fu_sel_o = owner_oh;
                    cnt_d    = cnt_q + 1'b1;
                    err_o    = foreign_vld;
                    if (owner_vld) begin
                        result_o       = owner_res;
                        result_valid_o = 1'b1;
                        if (result_ready_i) begin
                            state_d = EX_SEQ_IDLE;
                        end else begin
                            res_d   = owner_res;
                            state_d = EX_SEQ_HOLD;
                        end
                    end else if (expire) begin
                        timeout_o = 1'b1;
                        fu_kill_o = owner_oh;
                        state_d   = EX_SEQ_IDLE;
                    end
                end
                EX_SEQ_HOLD: begin
                    result_valid_o = 1'b1;
                    if (result_ready_i) state_d = EX_SEQ_IDLE;
                end
                default: state_d = EX_SEQ_IDLE;
            endcase

            if (kill_i) begin
                state_d        = EX_SEQ_IDLE;
                result_valid_o = 1'b0;
                fu_start_o     = '0;
                timeout_o      = 1'b0;
                fu_kill_o      = (state_q == EX_SEQ_BUSY) ? owner_oh : '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EX_SEQ_IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            init_q  <= 1'b1;
        end
    end

    ibex_ex_imd_regs #(
        .NumFu    (NumFu),
        .ImdWidth (ImdWidth)
    ) u_imd_regs (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (kill_i),
        .wr_en_i     (active && (state_q == EX_SEQ_BUSY) && !kill_i),
        .owner_i     (owner_q),
        .we_i        (fu_imd_we_i),
        .d_i         (fu_imd_d_i),
        .imd_val_q_o (imd_val_q_o)
    );

endmodule

// File: tb/tb_ibex_ex_fu_seq.sv
// Directed bench for ibex_ex_fu_seq with NumFu=3, CombFuMask=3'b001, MaxCycles=8.
module tb_ibex_ex_fu_seq;

    localparam int NFU = 3;
    localparam int DW  = 32;
    localparam int IW  = 34;

    logic               clk = 1'b0;
    logic               rst_ni;
    logic               issue_valid;
    logic               issue_ready;
    logic [1:0]         issue_fu;
    logic               kill;
    logic [NFU-1:0]     fu_start, fu_sel, fu_kill, fu_valid;
    logic [NFU*DW-1:0]  fu_result;
    logic [2*NFU-1:0]   imd_we;
    logic [2*NFU*IW-1:0] imd_d;
    logic [2*IW-1:0]    imd_val;
    logic [DW-1:0]      result;
    logic               result_valid, result_ready, timeout, err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ibex_ex_fu_seq #(
        .NumFu      (NFU),
        .DataWidth  (DW),
        .ImdWidth   (IW),
        .CombFuMask (3'b001),
        .MaxCycles  (8)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .issue_valid_i  (issue_valid),
        .issue_ready_o  (issue_ready),
        .issue_fu_i     (issue_fu),
        .kill_i         (kill),
        .fu_start_o     (fu_start),
        .fu_sel_o       (fu_sel),
        .fu_kill_o      (fu_kill),
        .fu_valid_i     (fu_valid),
        .fu_result_i    (fu_result),
        .fu_imd_we_i    (imd_we),
        .fu_imd_d_i     (imd_d),
        .imd_val_q_o    (imd_val),
        .result_o       (result),
        .result_valid_o (result_valid),
        .result_ready_i (result_ready),
        .timeout_o      (timeout),
        .err_o          (err)
    );

    typedef struct {
        logic        v;
        logic [1:0]  fu;
        logic        kill;
        logic [31:0] r0;
        logic        rdy;
        logic        e_rv;
        logic [31:0] e_ro;
        logic        e_ir;
        logic [2:0]  e_st;
        logic        e_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid  = 1'b0;
        issue_fu     = 2'd0;
        kill         = 1'b0;
        fu_valid     = '0;
        fu_result    = '0;
        imd_we       = '0;
        imd_d        = '0;
        result_ready = 1'b0;
    endtask

    task automatic issue(input logic [1:0] fu);
        issue_valid = 1'b1;
        issue_fu    = fu;
        @(negedge clk);
        tick();
        issue_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'd0, 1'b0, 32'h0000_00AB, 1'b1, 1'b1, 32'h0000_00AB, 1'b1, 3'b000, 1'b0};
        vecs[1] = '{1'b1, 2'd0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 3'b000, 1'b0};
        vecs[2] = '{1'b0, 2'd0, 1'b0, 32'h0000_1234, 1'b1, 1'b0, 32'h0,         1'b1, 3'b000, 1'b0};
        vecs[3] = '{1'b1, 2'd3, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0,         1'b1, 3'b000, 1'b1};
        vecs[4] = '{1'b1, 2'd1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0,         1'b0, 3'b000, 1'b0};
        vecs[5] = '{1'b1, 2'd0, 1'b0, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 3'b000, 1'b0};
        vecs[6] = '{1'b1, 2'd0, 1'b1, 32'h0000_0055, 1'b1, 1'b0, 32'h0,         1'b0, 3'b000, 1'b0};
        vecs[7] = '{1'b1, 2'd2, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0,         1'b1, 3'b100, 1'b0};

        // Reset, with a would-be zero-latency op pending on the inputs.
        clear_inputs();
        rst_ni       = 1'b0;
        issue_valid  = 1'b1;
        result_ready = 1'b1;
        fu_result[0 +: DW] = 32'hAB;
        tick();
        @(negedge clk);
        chk("rst_rvalid", result_valid, 1'b0);
        chk("rst_start", fu_start, 3'b000);
        tick();
        rst_ni = 1'b1;
        @(negedge clk);
        chk("post_rst_rvalid", result_valid, 1'b0);
        chk("post_rst_err", err, 1'b0);
        tick();
        clear_inputs();
        @(negedge clk);
        chk("rst_ready", issue_ready, 1'b1);
        chk("rst_imd", imd_val, 68'h0);
        chk("rst_result", result, 32'h0);
        tick();

        // Single-cycle IDLE behaviour. Vector 7 starts fu2 and is left to time out below.
        for (int i = 0; i < 7; i++) begin
            issue_valid  = vecs[i].v;
            issue_fu     = vecs[i].fu;
            kill         = vecs[i].kill;
            result_ready = vecs[i].rdy;
            fu_result[0 +: DW] = vecs[i].r0;
            @(negedge clk);
            chk($sformatf("vec%0d_rvalid", i), result_valid, vecs[i].e_rv);
            if (vecs[i].e_rv) chk($sformatf("vec%0d_result", i), result, vecs[i].e_ro);
            chk($sformatf("vec%0d_iready", i), issue_ready, vecs[i].e_ir);
            chk($sformatf("vec%0d_start", i), fu_start, vecs[i].e_st);
            chk($sformatf("vec%0d_err", i), err, vecs[i].e_err);
            tick();
        end
        clear_inputs();

        // Watchdog: fu2 never answers; expiry seven cycles after start.
        issue_valid = 1'b1;
        issue_fu    = vecs[7].fu;
        @(negedge clk);
        chk("to_start", fu_start, vecs[7].e_st);
        chk("to_iready0", issue_ready, vecs[7].e_ir);
        tick();
        issue_valid = 1'b0;
        for (int c = 1; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("to_wait%0d", c), {timeout, fu_kill, result_valid, issue_ready}, 6'b0);
            tick();
        end
        @(negedge clk);
        chk("to_timeout", timeout, 1'b1);
        chk("to_kill", fu_kill, 3'b100);
        chk("to_rvalid", result_valid, 1'b0);
        tick();
        @(negedge clk);
        chk("to_idle", issue_ready, 1'b1);
        chk("to_pulse_end", timeout, 1'b0);
        tick();

        // Owner valid on the expiry cycle beats the watchdog.
        issue(2'd1);
        repeat (6) tick();
        fu_valid[1]         = 1'b1;
        fu_result[DW +: DW] = 32'h1357_9BDF;
        result_ready        = 1'b1;
        @(negedge clk);
        chk("race_rvalid", result_valid, 1'b1);
        chk("race_result", result, 32'h1357_9BDF);
        chk("race_timeout", timeout, 1'b0);
        chk("race_kill", fu_kill, 3'b000);
        tick();
        clear_inputs();
        @(negedge clk);
        chk("race_idle", issue_ready, 1'b1);
        tick();

        // fu1 result at cycle 5 with ID stalled: HOLD until cycle 8.
        issue_valid = 1'b1;
        issue_fu    = 2'd1;
        @(negedge clk);
        chk("hold_start", fu_start, 3'b010);
        tick();
        issue_valid = 1'b0;
        for (int c = 1; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold_busy%0d", c), {issue_ready, result_valid, fu_sel}, 5'b00010);
            tick();
        end
        fu_valid[1]         = 1'b1;
        fu_result[DW +: DW] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("hold_c5_rvalid", result_valid, 1'b1);
        chk("hold_c5_result", result, 32'hDEAD_BEEF);
        tick();
        fu_valid  = '0;
        fu_result = '0;
        for (int c = 6; c < 9; c++) begin
            if (c == 8) result_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("hold_c%0d_rvalid", c), result_valid, 1'b1);
            chk($sformatf("hold_c%0d_result", c), result, 32'hDEAD_BEEF);
            chk($sformatf("hold_c%0d_iready", c), issue_ready, 1'b0);
            tick();
        end
        result_ready = 1'b0;
        @(negedge clk);
        chk("hold_c9_iready", issue_ready, 1'b1);
        chk("hold_c9_rvalid", result_valid, 1'b0);
        tick();

        // Owner-gated imd writes, non-owner valid error, then kill at cycle 3.
        issue(2'd1);
        imd_we[4] = 1'b1; imd_d[4*IW +: IW] = 34'h0_0000_0001;
        imd_we[5] = 1'b1; imd_d[5*IW +: IW] = 34'h3_FFFF_FFFF;
        imd_we[3] = 1'b1; imd_d[3*IW +: IW] = 34'h2_0000_0005;
        fu_valid[2] = 1'b1;
        @(negedge clk);
        chk("foreign_err", err, 1'b1);
        chk("foreign_rvalid", result_valid, 1'b0);
        tick();
        imd_we = '0; imd_d = '0; fu_valid = '0;
        @(negedge clk);
        chk("imd_owner_only", imd_val, {34'h2_0000_0005, 34'h0});
        imd_we[2] = 1'b1; imd_d[2*IW +: IW] = 34'h3_0000_0001;
        imd_we[3] = 1'b1; imd_d[3*IW +: IW] = 34'h1_1111_1111;
        tick();
        imd_we = '0; imd_d = '0;
        kill        = 1'b1;
        issue_valid = 1'b1;
        issue_fu    = 2'd1;
        @(negedge clk);
        chk("imd_both", imd_val, {34'h1_1111_1111, 34'h3_0000_0001});
        chk("kill_fu_kill", fu_kill, 3'b010);
        chk("kill_start", fu_start, 3'b000);
        chk("kill_iready", issue_ready, 1'b0);
        tick();
        clear_inputs();
        @(negedge clk);
        chk("kill_imd_clr", imd_val, 68'h0);
        chk("kill_idle", issue_ready, 1'b1);
        chk("kill_pulse_end", fu_kill, 3'b000);
        tick();

        // Comb unit stalled into HOLD, then reset for one edge.
        issue_valid        = 1'b1;
        fu_result[0 +: DW] = 32'h77;
        @(negedge clk);
        chk("chold_rvalid", result_valid, 1'b1);
        chk("chold_result", result, 32'h77);
        tick();
        clear_inputs();
        @(negedge clk);
        chk("chold_reg", result, 32'h77);
        chk("chold_iready", issue_ready, 1'b0);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        @(negedge clk);
        chk("hrst_rvalid", result_valid, 1'b0);
        tick();
        @(negedge clk);
        chk("hrst_idle", issue_ready, 1'b1);
        chk("hrst_result", result, 32'h0);
        tick();

        // Reset in BUSY drops the op without a kill pulse.
        issue(2'd2);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("brst_kill", fu_kill, 3'b000);
        tick();
        rst_ni = 1'b1;
        @(negedge clk);
        chk("brst_post_kill", {fu_kill, timeout}, 4'b0);
        tick();
        @(negedge clk);
        chk("brst_idle", issue_ready, 1'b1);
        chk("brst_sel", fu_sel, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
